// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU control sequencer: operation codes, aluOp/funct/opcode
// encodings, FSM states and the latency-counter width helper.
package alu_ctrl_pkg;

  localparam logic [31:0] OP_SLL     = 32'd0;
  localparam logic [31:0] OP_SRL     = 32'd1;
  localparam logic [31:0] OP_SRA     = 32'd2;
  localparam logic [31:0] OP_ADD     = 32'd3;
  localparam logic [31:0] OP_SUB     = 32'd4;
  localparam logic [31:0] OP_AND     = 32'd5;
  localparam logic [31:0] OP_OR      = 32'd6;
  localparam logic [31:0] OP_XOR     = 32'd7;
  localparam logic [31:0] OP_NOR     = 32'd8;
  localparam logic [31:0] OP_SLT     = 32'd9;
  localparam logic [31:0] OP_MULT    = 32'd10;
  localparam logic [31:0] OP_DIV     = 32'd11;
  localparam logic [31:0] OP_SLTU    = 32'd12;
  localparam logic [31:0] OP_LUI     = 32'd13;
  localparam logic [31:0] OP_INVALID = 32'hFFFF_FFFF;

  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_IMM    = 2'b11;

  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SLLV  = 6'b000100;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_SRLV  = 6'b000110;
  localparam logic [5:0] FN_SRA   = 6'b000011;
  localparam logic [5:0] FN_SRAV  = 6'b000111;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLTU  = 6'b101011;

  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_ADDIU = 6'b001001;
  localparam logic [5:0] OPC_SLTI  = 6'b001010;
  localparam logic [5:0] OPC_SLTIU = 6'b001011;
  localparam logic [5:0] OPC_ANDI  = 6'b001100;
  localparam logic [5:0] OPC_ORI   = 6'b001101;
  localparam logic [5:0] OPC_XORI  = 6'b001110;
  localparam logic [5:0] OPC_LUI   = 6'b001111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_VALID = 2'd2
  } state_t;

  // Counter must hold the longest latency, so size it from the larger of the two.
  function automatic int cntWidth(int multCycles, int divCycles);
    int longest;
    longest = (multCycles > divCycles) ? multCycles : divCycles;
    return $clog2(longest) + 1;
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational decode of (aluOp, funct, opcode) into operation code, illegal flag and latency.
// DIV/DIVU decode only when ALU_CTRL_DIV_EN is defined; otherwise they are illegal.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter int OP_W        = 4,
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32,
  localparam int CNT_W      = cntWidth(MULT_CYCLES, DIV_CYCLES)
) (
  input  logic [1:0]       i_aluOp,
  input  logic [5:0]       i_functCode,
  input  logic [5:0]       i_opCode,
  output logic [OP_W-1:0]  o_code,
  output logic             o_illegal,
  output logic             o_multiCycle,
  output logic [CNT_W-1:0] o_cycles
);

  logic [31:0]      w_op;
  logic [CNT_W-1:0] w_cycles;

  always_comb begin
    w_op     = OP_INVALID;
    w_cycles = CNT_W'(1);
    case (i_aluOp)
      ALUOP_MEM:    w_op = OP_ADD;
      ALUOP_BRANCH: w_op = OP_SUB;
      ALUOP_RTYPE: begin
        case (i_functCode)
          FN_SLL, FN_SLLV:  w_op = OP_SLL;
          FN_SRL, FN_SRLV:  w_op = OP_SRL;
          FN_SRA, FN_SRAV:  w_op = OP_SRA;
          FN_ADD, FN_ADDU:  w_op = OP_ADD;
          FN_SUB, FN_SUBU:  w_op = OP_SUB;
          FN_AND:           w_op = OP_AND;
          FN_OR:            w_op = OP_OR;
          FN_XOR:           w_op = OP_XOR;
          FN_NOR:           w_op = OP_NOR;
          FN_SLT:           w_op = OP_SLT;
          FN_SLTU:          w_op = OP_SLTU;
          FN_MULT, FN_MULTU: begin
            w_op     = OP_MULT;
            w_cycles = CNT_W'(MULT_CYCLES);
          end
`ifdef ALU_CTRL_DIV_EN
          FN_DIV, FN_DIVU: begin
            w_op     = OP_DIV;
            w_cycles = CNT_W'(DIV_CYCLES);
          end
`else
          FN_DIV, FN_DIVU:  w_op = OP_INVALID;
`endif
          default:          w_op = OP_INVALID;
        endcase
      end
      ALUOP_IMM: begin
        case (i_opCode)
          OPC_ADDI, OPC_ADDIU: w_op = OP_ADD;
          OPC_ANDI:            w_op = OP_AND;
          OPC_ORI:             w_op = OP_OR;
          OPC_XORI:            w_op = OP_XOR;
          OPC_SLTI:            w_op = OP_SLT;
          OPC_SLTIU:           w_op = OP_SLTU;
          OPC_LUI:             w_op = OP_LUI;
          default:             w_op = OP_INVALID;
        endcase
      end
      default: w_op = OP_INVALID;
    endcase
  end

  // Illegal codes stay at latency 1, so only a legal multi-cycle op can start BUSY.
  assign o_illegal    = (w_op == OP_INVALID);
  assign o_code       = o_illegal ? '1 : OP_W'(w_op);
  assign o_cycles     = w_cycles;
  assign o_multiCycle = (w_cycles > CNT_W'(1));

endmodule

// File: rtl/alu_ctrl_sequencer.sv
// Registered, valid/ready-handshaked ALU control with multi-cycle MULT (and DIV when
// ALU_CTRL_DIV_EN is defined), upstream stall via busy, and a pipeline flush.
module alu_ctrl_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int OP_W        = 4,
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            inValid,
  output logic            inReady,
  input  logic [1:0]      aluOp,
  input  logic [5:0]      functCode,
  input  logic [5:0]      opCode,
  input  logic            flush,
  output logic            outValid,
  input  logic            outReady,
  output logic [OP_W-1:0] aluOperation,
  output logic            busy,
  output logic            illegal
);

  localparam int CNT_W = cntWidth(MULT_CYCLES, DIV_CYCLES);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [OP_W-1:0]  r_op;
  logic             r_illegal;
  logic             r_outValid;
  logic             r_busy;

  logic [OP_W-1:0]  w_code;
  logic             w_illegal;
  logic             w_multiCycle;
  logic [CNT_W-1:0] w_cycles;
  logic             w_accept;

  alu_ctrl_decode #(
    .OP_W        (OP_W),
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_decode (
    .i_aluOp      (aluOp),
    .i_functCode  (functCode),
    .i_opCode     (opCode),
    .o_code       (w_code),
    .o_illegal    (w_illegal),
    .o_multiCycle (w_multiCycle),
    .o_cycles     (w_cycles)
  );

  // VALID accepts back-to-back only when the held result is consumed this cycle.
  assign inReady  = !flush && ((r_state == ST_IDLE) || ((r_state == ST_VALID) && outReady));
  assign w_accept = inValid && inReady;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_op       <= '1;
      r_illegal  <= 1'b0;
      r_outValid <= 1'b0;
      r_busy     <= 1'b0;
    end else if (flush) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_outValid <= 1'b0;
      r_busy     <= 1'b0;
    end else if (w_accept) begin
      r_op      <= w_code;
      r_illegal <= w_illegal;
      if (w_multiCycle) begin
        r_state    <= ST_BUSY;
        r_cnt      <= w_cycles - CNT_W'(1);
        r_outValid <= 1'b0;
        r_busy     <= 1'b1;
      end else begin
        r_state    <= ST_VALID;
        r_cnt      <= '0;
        r_outValid <= 1'b1;
        r_busy     <= 1'b0;
      end
    end else begin
      case (r_state)
        ST_BUSY: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state    <= ST_VALID;
            r_outValid <= 1'b1;
            r_busy     <= 1'b0;
          end
        end
        ST_VALID: begin
          if (outReady) begin
            r_state    <= ST_IDLE;
            r_outValid <= 1'b0;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_outValid <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign aluOperation = r_op;
  assign illegal      = r_illegal;
  assign outValid     = r_outValid;
  assign busy         = r_busy;

endmodule

// File: doc/alu_ctrl_sequencer.md
Name: alu_ctrl_sequencer

Overview:
Registered, handshaked successor to the combinational ALU control decoder. It sits between the ID/EX pipeline register and the ALU.
- Decodes aluOp, funct and opcode into a parametrised-width ALU operation code.
- Adds multi-cycle operations (MULT, optional DIV) that hold the operation stable while a latency counter runs, and stall upstream for that time.
- Supports a valid/ready handshake in both directions and a pipeline flush.

Parameters:
OP_W, 4, width of aluOperation; must be >= 4; the invalid code is all ones.
MULT_CYCLES, 4, ALU cycles for MULT/MULTU; must be >= 1; 1 means single-cycle.
DIV_CYCLES, 32, ALU cycles for DIV/DIVU; must be >= 1; used only with the optional feature.

Ports:
clk  in  1  single clock, rising edge
reset  in  1  synchronous, active-high
inValid  in  1  decode request present
inReady  out  1  request accepted this cycle when inValid && inReady
aluOp  in  2  00 load/store, 01 branch, 10 R-type, 11 immediate
functCode  in  6  instruction bits [5:0]
opCode  in  6  instruction bits [31:26]
flush  in  1  discard the held or in-flight operation
outValid  out  1  aluOperation is final and consumable
outReady  in  1  downstream accepts when outValid && outReady
aluOperation  out  OP_W  registered operation code
busy  out  1  multi-cycle operation in progress; doubles as the pipeline stall
illegal  out  1  registered with aluOperation; the decoded code was invalid

Behaviour:
Operation codes:
- 0 SLL, 1 SRL, 2 SRA, 3 ADD, 4 SUB, 5 AND, 6 OR, 7 XOR, 8 NOR, 9 SLT
- 10 MULT, 11 DIV, 12 SLTU, 13 LUI
- all-ones = invalid

Decode by aluOp:
- 00 → ADD.
- 01 → SUB.
- 10 (R-type, by funct):
  - 000000/000100 → SLL; 000010/000110 → SRL; 000011/000111 → SRA
  - 100000/100001 → ADD; 100010/100011 → SUB
  - 100100 AND; 100101 OR; 100110 XOR; 100111 NOR
  - 101010 SLT; 101011 SLTU
  - 011000/011001 → MULT; 011010/011011 → DIV (only with the optional feature)
- 11 (immediate, by opcode):
  - 001000/001001 → ADD; 001100 AND; 001101 OR; 001110 XOR
  - 001010 SLT; 001011 SLTU; 001111 LUI
- Anything else → all-ones with illegal=1. An illegal operation is handled as single-cycle.

FSM states: IDLE, BUSY, VALID.
- IDLE:
  - inReady=1, outValid=0, busy=0.
  - Accept single-cycle op → VALID.
  - Accept multi-cycle op with N>1 → BUSY, cnt=N-1.
- BUSY:
  - inReady=0, outValid=0, busy=1; cnt decrements each cycle.
  - When cnt==1 and it decrements, the next state is VALID.
  - Total cycles from accept to outValid = N.
- VALID:
  - outValid=1; inReady=outReady (back-to-back acceptance).
  - outReady=0 → hold; all outputs stable.
  - outReady=1 with no new request → IDLE.
  - outReady=1 with a new request → reload, next state as from IDLE.

Timing and register rules:
- Latency: single-cycle ops give outValid the cycle after accept. Throughput is 1 op/cycle when outReady is held high.
- aluOperation and illegal load only on accept and are held through BUSY and VALID.
- Counter width is clog2(max(MULT_CYCLES, DIV_CYCLES))+1.

Priority: reset > flush > normal operation.
- reset: state IDLE, cnt=0, outValid=0, busy=0, illegal=0, aluOperation=all-ones.
- flush: state IDLE, cnt=0, outValid=0, busy=0. aluOperation and illegal keep their value. inValid in the same cycle is ignored (inReady is forced to 0).
- reset or flush asserted mid-BUSY aborts the operation with no outValid pulse.
- inValid while BUSY is not accepted; upstream must hold the request.

Optional Feature:
Macro ALU_CTRL_DIV_EN.
- Defined: funct 011010/011011 decode to code 11, multi-cycle for DIV_CYCLES.
- Undefined: those functs decode to all-ones with illegal=1, single-cycle, and DIV_CYCLES is unused.

Decomposition:
Package alu_ctrl_pkg holds:
- operation-code localparams (OP_SLL..OP_LUI, OP_INVALID)
- aluOp encodings (ALUOP_MEM, ALUOP_BRANCH, ALUOP_RTYPE, ALUOP_IMM)
- funct and opcode constants
- FSM state encodings

One combinational sub-module, alu_ctrl_decode, maps (aluOp, functCode, opCode) to (code, illegal, multiCycle, cycles). The top level holds the FSM, counter and output registers.

Test Plan:
1. Reset with inValid=1, aluOp=10, funct=100000 → outputs all-ones/0/0 during reset; first accept after release gives aluOperation=3, outValid=1 one cycle later.
2. Back-to-back ADD, SUB, SLTU (funct 100000, 100010, 101011) with outReady=1 → codes 3, 4, 12 on consecutive cycles; inReady stays 1.
3. MULT (funct 011000) with MULT_CYCLES=4 → busy=1 for 3 cycles, outValid on the 4th cycle after accept, aluOperation=10 throughout; a second inValid during busy is not accepted.
4. VALID with outReady=0 for 5 cycles → aluOperation/outValid stable, inReady=0; outReady=1 then releases the op.
5. flush on the 2nd BUSY cycle of MULT → next cycle IDLE, busy=0, no outValid pulse; the simultaneous inValid is ignored.
6. DIV (funct 011010): with ALU_CTRL_DIV_EN and DIV_CYCLES=32 → outValid 32 cycles after accept, code 11; without the macro → code all-ones, illegal=1 after 1 cycle; aluOp=11 with opcode 000001 → illegal=1.
